pipe_chain: RTL and testbench

PIPE_CHAIN -- requirements
Module: pipe_chain

---
 rtl/pipe_pkg.sv | 30 +++
 rtl/pipe_slot.sv | 62 ++++++
 rtl/pipe_chain.sv | 128 ++++++++++++
 tb/tb_pipe_chain.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pipe_pkg
// Description : Shared constants and helpers for the pipe_chain register
//               pipeline: default payload width, depth, drop-counter width,
//               and a population-count function over the stage valid bits.
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
package pipe_pkg;

  localparam int c_def_data_w = 32;
  localparam int c_def_depth  = 4;
  localparam int c_def_cnt_w  = 16;

  // Widest chain supported; popcount operates on a vector padded to this.
  localparam int c_max_depth  = 8;
  localparam int c_pop_w      = 4;

  function automatic logic [c_pop_w-1:0] popcount(input logic [c_max_depth-1:0] vec);
    logic [c_pop_w-1:0] cnt;
    cnt = '0;
    for (int i = 0; i < c_max_depth; i++) begin
      cnt = cnt + {{(c_pop_w-1){1'b0}}, vec[i]};
    end
    return cnt;
  endfunction

endpackage
`default_nettype wire

// File: rtl/pipe_slot.sv
`default_nettype none
// ============================================================================
// Module      : pipe_slot
// Description : One pipeline stage: valid/data registers plus the
//               load / hold / clear decision. Handshake qualification
//               (accept/send) is computed by the parent's ready chain.
// Ports       : clk, reset        - clock, async active-high reset
//               i_flush           - squash this stage's item on this edge
//               i_accept          - stage may take a new item this cycle
//               i_send            - stage hands its item onward this cycle
//               i_recv_valid/data - item offered by the predecessor
//               o_valid/o_data    - registered stage contents
// Revision    : 1.0 - initial release
// ============================================================================
module pipe_slot
  import pipe_pkg::*;
#(
  parameter int DATA_W = c_def_data_w
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_flush,
  input  logic              i_accept,
  input  logic              i_send,
  input  logic              i_recv_valid,
  input  logic [DATA_W-1:0] i_recv_data,
  output logic              o_valid,
  output logic [DATA_W-1:0] o_data
);

  logic              valid_q, valid_d;
  logic [DATA_W-1:0] data_q,  data_d;

  // Flush wins over everything; a stalled stage has accept=send=0 and holds.
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (i_flush) begin
      valid_d = 1'b0;
    end else if (i_accept && i_recv_valid) begin
      valid_d = 1'b1;
      data_d  = i_recv_data;
    end else if (i_send) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign o_valid = valid_q;
  assign o_data  = data_q;

endmodule
`default_nettype wire

// File: rtl/pipe_chain.sv
`default_nettype none
// ============================================================================
// Module      : pipe_chain
// Description : DEPTH-stage bubble-collapsing register pipeline with per-stage
//               stall and flush, full throughput via a combinational ready
//               chain, occupancy report and a saturating flush-drop counter.
// Ports       : clk, reset                    - clock, async active-high reset
//               in_valid/in_ready/in_data     - upstream handshake
//               out_valid/out_ready/out_data  - downstream handshake
//               stall_mask, flush_mask        - per-stage hold / squash
//               occupancy                     - number of valid stages
//               drop_count                    - items squashed (saturating)
// Revision    : 1.0 - initial release
// ============================================================================
module pipe_chain
  import pipe_pkg::*;
#(
  parameter int DATA_W = c_def_data_w,
  parameter int DEPTH  = c_def_depth,
  parameter int CNT_W  = c_def_cnt_w
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [DATA_W-1:0]          in_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [DATA_W-1:0]          out_data,
  input  logic [DEPTH-1:0]           stall_mask,
  input  logic [DEPTH-1:0]           flush_mask,
  output logic [$clog2(DEPTH+1)-1:0] occupancy,
  output logic [CNT_W-1:0]           drop_count
);

  localparam int OCC_W = $clog2(DEPTH+1);

  logic [DEPTH-1:0]  valid_q;
  logic [DATA_W-1:0] data_q [DEPTH];

  logic [DEPTH-1:0]  w_blocked;
  logic [DEPTH-1:0]  w_send;
  // w_accept[DEPTH] is the output port; w_accept[i] is stage i accepting.
  logic [DEPTH:0]    w_accept;

  logic [CNT_W-1:0]  drop_count_q, drop_count_d;
  logic [c_max_depth-1:0] w_valid_pad;
  logic [c_max_depth-1:0] w_drop_pad;
  logic [c_pop_w-1:0]     w_drop_inc;
  logic [CNT_W+c_pop_w-1:0] w_drop_sum;

  // Ready chain, evaluated from the output back toward stage 0 so each
  // stage sees its successor's accept in the same cycle.
  always_comb begin
    w_blocked       = stall_mask | flush_mask;
    w_send          = '0;
    w_accept        = '0;
    w_accept[DEPTH] = out_ready;
    for (int i = DEPTH-1; i >= 0; i--) begin
      w_send[i]   = valid_q[i] & ~w_blocked[i] & w_accept[i+1];
      w_accept[i] = ~w_blocked[i] & (~valid_q[i] | w_send[i]);
    end
  end

  for (genvar i = 0; i < DEPTH; i++) begin : g_slot
    logic              w_recv_valid;
    logic [DATA_W-1:0] w_recv_data;

    if (i == 0) begin : g_head
      assign w_recv_valid = in_valid;
      assign w_recv_data  = in_data;
    end else begin : g_body
      // A blocked predecessor never asserts send, so its successor sees a bubble.
      assign w_recv_valid = w_send[i-1];
      assign w_recv_data  = data_q[i-1];
    end

    pipe_slot #(
      .DATA_W (DATA_W)
    ) u_slot (
      .clk          (clk),
      .reset        (reset),
      .i_flush      (flush_mask[i]),
      .i_accept     (w_accept[i]),
      .i_send       (w_send[i]),
      .i_recv_valid (w_recv_valid),
      .i_recv_data  (w_recv_data),
      .o_valid      (valid_q[i]),
      .o_data       (data_q[i])
    );
  end

  assign in_ready  = w_accept[0];
  assign out_valid = valid_q[DEPTH-1] & ~w_blocked[DEPTH-1];
  assign out_data  = data_q[DEPTH-1];

  always_comb begin
    w_valid_pad             = '0;
    w_drop_pad              = '0;
    w_valid_pad[DEPTH-1:0]  = valid_q;
    w_drop_pad[DEPTH-1:0]   = valid_q & flush_mask;
  end

  // Occupancy depends only on registered valid bits.
  assign occupancy  = OCC_W'(popcount(w_valid_pad));

  assign w_drop_inc = popcount(w_drop_pad);
  assign w_drop_sum = {{c_pop_w{1'b0}}, drop_count_q} + {{CNT_W{1'b0}}, w_drop_inc};

  always_comb begin
    drop_count_d = w_drop_sum[CNT_W-1:0];
    if (w_drop_sum[CNT_W+c_pop_w-1:CNT_W] != '0) begin
      drop_count_d = '1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      drop_count_q <= '0;
    end else begin
      drop_count_q <= drop_count_d;
    end
  end

  assign drop_count = drop_count_q;

endmodule
`default_nettype wire

// File: tb/tb_pipe_chain.sv
`default_nettype none
// ============================================================================
// Module      : tb_pipe_chain
// Description : Directed self-checking bench for pipe_chain (DEPTH=4,
//               DATA_W=32, CNT_W=16) plus a 4-bit-counter instance sharing
//               the same stimulus for the drop-counter saturation scenario.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pipe_chain;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic [3:0]  stall_mask;
  logic [3:0]  flush_mask;
  logic [2:0]  occupancy;
  logic [15:0] drop_count;

  logic        sat_in_ready;
  logic        sat_out_valid;
  logic [31:0] sat_out_data;
  logic [2:0]  sat_occupancy;
  logic [3:0]  sat_drop_count;

  int n_pass  = 0;
  int n_total = 0;

  pipe_chain #(.DATA_W(32), .DEPTH(4), .CNT_W(16)) dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .stall_mask (stall_mask),
    .flush_mask (flush_mask),
    .occupancy  (occupancy),
    .drop_count (drop_count)
  );

  pipe_chain #(.DATA_W(32), .DEPTH(4), .CNT_W(4)) dut_sat (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (sat_in_ready),
    .in_data    (in_data),
    .out_valid  (sat_out_valid),
    .out_ready  (out_ready),
    .out_data   (sat_out_data),
    .stall_mask (stall_mask),
    .flush_mask (flush_mask),
    .occupancy  (sat_occupancy),
    .drop_count (sat_drop_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
  endtask

  task automatic push_n(input int n, input logic [31:0] base);
    in_valid = 1'b1;
    for (int i = 0; i < n; i++) begin
      in_data = base + 32'(i);
      tick();
    end
    in_valid = 1'b0;
  endtask

  task automatic flush_once(input logic [3:0] m);
    flush_mask = m;
    tick();
    flush_mask = 4'b0000;
    #1;
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    stall_mask = '0; flush_mask = '0;

    // ---------------- reset state ----------------
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_occupancy", occupancy, 0);
    check("rst_drop",      drop_count, 0);
    check("rst_in_ready",  in_ready, 1);
    check("rst_out_data",  out_data, 0);
    stall_mask = 4'b0001; #1;
    check("rst_in_ready_stall0", in_ready, 0);
    stall_mask = 4'b0000; flush_mask = 4'b0001; #1;
    check("rst_in_ready_flush0", in_ready, 0);
    flush_mask = 4'b0000;
    tick(); tick();
    reset = 1'b0;

    // ---------------- stream ----------------
    out_ready = 1'b1; in_valid = 1'b1; in_data = 32'h11; #1;
    check("str_in_ready", in_ready, 1);
    tick(); in_data = 32'h22;
    tick(); in_data = 32'h33;
    tick(); in_valid = 1'b0; #1;
    check("str_occ3",   occupancy, 3);
    check("str_no_out", out_valid, 0);
    tick();
    check("str_v11", out_valid, 1);
    check("str_d11", out_data, 32'h11);
    tick();
    check("str_v22", out_valid, 1);
    check("str_d22", out_data, 32'h22);
    tick();
    check("str_v33", out_valid, 1);
    check("str_d33", out_data, 32'h33);
    tick();
    check("str_empty_v",   out_valid, 0);
    check("str_empty_occ", occupancy, 0);

    // ---------------- backpressure ----------------
    out_ready = 1'b0;
    push_n(4, 32'hA1);
    in_valid = 1'b1; in_data = 32'hA5; #1;
    check("bp_occ4",     occupancy, 4);
    check("bp_in_ready", in_ready, 0);
    check("bp_out_v",    out_valid, 1);
    check("bp_out_a1",   out_data, 32'hA1);
    out_ready = 1'b1; #1;
    check("bp_in_ready_same_cycle", in_ready, 1);
    tick(); in_valid = 1'b0;
    for (int k = 2; k <= 5; k++) begin
      check("bp_drain_v", out_valid, 1);
      check("bp_drain_d", out_data, 32'hA0 + 32'(k));
      tick();
    end
    check("bp_empty", occupancy, 0);

    // ---------------- stall stage 1 for two cycles ----------------
    out_ready = 1'b1; in_valid = 1'b1;
    in_data = 32'hB1; tick();
    in_data = 32'hB2; tick();
    in_data = 32'hB3; tick();
    stall_mask = 4'b0010; in_data = 32'hB4; #1;
    check("st_in_ready0", in_ready, 0);
    tick();
    check("st_out_v_b1", out_valid, 1);
    check("st_out_b1",   out_data, 32'hB1);
    check("st_occ3",     occupancy, 3);
    check("st_in_ready1", in_ready, 0);
    tick();
    check("st_bubble_v", out_valid, 0);
    check("st_occ2",     occupancy, 2);
    stall_mask = 4'b0000; #1;
    check("st_release_ready", in_ready, 1);
    tick(); in_valid = 1'b0; #1;
    check("st_occ_after", occupancy, 3);
    check("st_bubble2_v", out_valid, 0);
    for (int k = 2; k <= 4; k++) begin
      tick();
      check("st_order_v", out_valid, 1);
      check("st_order_d", out_data, 32'hB0 + 32'(k));
    end
    tick();
    check("st_empty", occupancy, 0);

    // ---------------- flush 0111 with full chain ----------------
    out_ready = 1'b0;
    push_n(4, 32'hC1);
    flush_mask = 4'b0111; #1;
    check("fl_in_ready", in_ready, 0);
    check("fl_out_v",    out_valid, 1);
    check("fl_out_c1",   out_data, 32'hC1);
    tick(); flush_mask = 4'b0000; #1;
    check("fl_occ1",    occupancy, 1);
    check("fl_drop3",   drop_count, 3);
    check("fl_sat3",    sat_drop_count, 3);
    check("fl_keep_v",  out_valid, 1);
    check("fl_keep_c1", out_data, 32'hC1);
    out_ready = 1'b1; tick();
    check("fl_drained", occupancy, 0);

    // ---------------- saturation (4-bit counter instance) ----------------
    out_ready = 1'b0;
    push_n(4, 32'hD1); flush_once(4'b1111);
    check("sat_drop7", drop_count, 7);
    push_n(4, 32'hD5); flush_once(4'b1111);
    push_n(4, 32'hD9); flush_once(4'b0111);
    check("sat_drop14",   drop_count, 14);
    check("sat_small14",  sat_drop_count, 14);
    check("sat_occ1",     occupancy, 1);
    push_n(3, 32'hE1);
    check("sat_full",     occupancy, 4);
    flush_once(4'b1001);
    check("sat_drop16",   drop_count, 16);
    check("sat_small_max", sat_drop_count, 15);
    check("sat_occ2",     occupancy, 2);
    flush_once(4'b0110);
    check("sat_drop18",   drop_count, 18);
    check("sat_small_hold", sat_drop_count, 15);
    check("sat_occ0",     sat_occupancy, 0);
    check("sat_in_ready", sat_in_ready, 1);

    // ---------------- reset mid-stream ----------------
    push_n(3, 32'hE1);
    tick(); #1;
    check("rm_occ3",  occupancy, 3);
    check("rm_out_v", out_valid, 1);
    check("rm_out_d", out_data, 32'hE1);
    check("rm_sat_d", sat_out_data, 32'hE1);
    reset = 1'b1; #1;
    check("rm_out_v0",  out_valid, 0);
    check("rm_occ0",    occupancy, 0);
    check("rm_drop0",   drop_count, 0);
    check("rm_sat0",    sat_drop_count, 0);
    check("rm_sat_v0",  sat_out_valid, 0);
    tick(); reset = 1'b0;
    out_ready = 1'b1; in_valid = 1'b1; in_data = 32'hF1; tick();
    in_data = 32'hF2; tick();
    in_valid = 1'b0; tick(); #1;
    check("rm_pre_v", out_valid, 0);
    tick();
    check("rm_f1_v", out_valid, 1);
    check("rm_f1_d", out_data, 32'hF1);
    tick();
    check("rm_f2_d", out_data, 32'hF2);
    tick();
    check("rm_end_occ",  occupancy, 0);
    check("rm_end_drop", drop_count, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
